// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state encoding, defaults and signature helper for the commit trace buffer
package trace_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;

  // Widest signature the rotate helper supports; callers zero-extend into it.
  localparam int SIG_MAX_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  // Rotate left by one within the low w bits. Bits above w-1 of v must be zero;
  // the caller truncates the result back to w bits.
  function automatic logic [SIG_MAX_W-1:0] rotl1(input logic [SIG_MAX_W-1:0] v,
                                                 input int unsigned w);
    return (v << 1) | ((v >> (w - 1)) & SIG_MAX_W'(1));
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with occupancy and simultaneous push/pop
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign head    = mem[rd_ptr_q];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; clr empties the FIFO at the start of a run.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - writeback capture FIFO, running signature and run/drain/check FSM
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int CNT_W    = 16,
  parameter int N_RETIRE = 64,
  parameter int TIMEOUT  = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   wb_valid,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic [DATA_W-1:0]      exp_sig,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  input  logic                   rd_ready,
  output logic [DATA_W-1:0]      signature,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   timeout,
  output logic                   done,
  output logic                   pass
);

  trace_state_t      state_q, state_d;
  logic [DATA_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              ovf_q, ovf_d;
  logic              to_q, to_d;
  logic              sig_ok_q, sig_ok_d;

  logic              fifo_clr, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              in_run, hit_ret, hit_to;

  assign in_run    = (state_q == ST_RUN);
  assign rd_valid  = ~fifo_empty & (in_run | (state_q == ST_DRAIN));
  assign fifo_pop  = rd_valid & rd_ready;
  assign fifo_push = in_run & wb_valid & (~fifo_full | fifo_pop);
  assign rd_data   = rd_valid ? fifo_head : '0;

  trace_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .push_data (wb_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Run control: fold retirements, pick the run-ending cause, wait for drain.
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    ret_d    = ret_q;
    cyc_d    = cyc_q;
    ovf_d    = ovf_q;
    to_d     = to_q;
    sig_ok_d = sig_ok_q;
    fifo_clr = 1'b0;
    hit_ret  = 1'b0;
    hit_to   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          sig_d    = '0;
          ret_d    = '0;
          cyc_d    = '0;
          ovf_d    = 1'b0;
          to_d     = 1'b0;
          sig_ok_d = 1'b0;
          fifo_clr = 1'b1;
        end
      end
      ST_RUN: begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
        if (wb_valid) begin
          // Dropped values still count and still fold into the signature.
          sig_d = DATA_W'(rotl1(SIG_MAX_W'(sig_q), DATA_W)) ^ wb_data;
          ret_d = (&ret_q) ? ret_q : ret_q + CNT_W'(1);
          if (fifo_full && !fifo_pop) ovf_d = 1'b1;
        end
        hit_ret = wb_valid && (N_RETIRE != 0) && (ret_d == CNT_W'(N_RETIRE));
        hit_to  = (TIMEOUT != 0) && (cyc_q == CNT_W'(TIMEOUT - 1));
        if (stop || hit_ret || hit_to) begin
          state_d  = ST_DRAIN;
          // Compare against the signature including this cycle's retirement.
          sig_ok_d = (sig_d == exp_sig);
          // Timeout is flagged only when it is the cause that ended the run.
          if (!stop && !hit_ret) to_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, signature, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sig_q    <= '0;
      ret_q    <= '0;
      cyc_q    <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      sig_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      ret_q    <= ret_d;
      cyc_q    <= cyc_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
      sig_ok_q <= sig_ok_d;
    end
  end

  assign signature  = sig_q;
  assign retire_cnt = ret_q;
  assign overflow   = ovf_q;
  assign timeout    = to_q;
  assign done       = (state_q == ST_DONE);
  assign pass       = done & sig_ok_q & ~ovf_q & ~to_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - directed self-checking bench for commit_trace_buffer
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        rst, start, stop, wb_valid, rd_ready;
  logic [31:0] wb_data, exp_sig;
  logic        rd_valid, overflow, timeout, done, pass;
  logic [31:0] rd_data, signature;
  logic [15:0] retire_cnt;
  logic [4:0]  level;

  int checks   = 0;
  int failures = 0;

  commit_trace_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .exp_sig    (exp_sig),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .signature  (signature),
    .retire_cnt (retire_cnt),
    .level      (level),
    .overflow   (overflow),
    .timeout    (timeout),
    .done       (done),
    .pass       (pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] d);
    wb_valid = 1'b1;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop(input logic [31:0] e);
    exp_sig = e;
    stop    = 1'b1;
    tick();
    stop    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; wb_valid = 1'b0;
    rd_ready = 1'b0; wb_data = '0; exp_sig = '0;
    tick();
    rst = 1'b0;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sig", signature, 0);
    chk("rst_level", level, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ovf", overflow, 0);

    // Reset mid-run: 5,6,7 -> rotl(5)^6=0xC, rotl(0xC)^7=0x1F
    do_start();
    retire(32'd5); retire(32'd6); retire(32'd7);
    chk("t1_level", level, 3);
    chk("t1_sig", signature, 32'h1F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_level_rst", level, 0);
    chk("t1_rdv_rst", rd_valid, 0);
    chk("t1_sig_rst", signature, 0);
    chk("t1_done_rst", done, 0);
    chk("t1_ret_rst", retire_cnt, 0);

    // Basic run: 1 then 2 gives signature 1 then 0
    do_start();
    retire(32'd1);
    chk("t2_sig1", signature, 32'h1);
    chk("t2_rdv", rd_valid, 1);
    chk("t2_rd1", rd_data, 32'd1);
    retire(32'd2);
    chk("t2_sig2", signature, 32'h0);
    do_stop(32'h0);
    chk("t2_drain_rd1", rd_data, 32'd1);
    rd_ready = 1'b1;
    tick();
    chk("t2_drain_rd2", rd_data, 32'd2);
    tick();
    chk("t2_empty", rd_valid, 0);
    wait_done("t2_done");
    chk("t2_pass", pass, 1);
    rd_ready = 1'b0;

    // Rotate wrap and signature mismatch
    do_start();
    chk("t3_done_clr", done, 0);
    chk("t3_sig_clr", signature, 0);
    chk("t3_ret_clr", retire_cnt, 0);
    rd_ready = 1'b1;
    retire(32'h8000_0000);
    chk("t3_sig1", signature, 32'h8000_0000);
    retire(32'h0000_0001);
    chk("t3_sig2", signature, 32'h0);
    do_stop(32'h1);
    wait_done("t3_done");
    chk("t3_pass", pass, 0);
    rd_ready = 1'b0;

    // Overflow: 17 values into a 16-deep FIFO
    do_start();
    for (int i = 1; i <= 16; i++) retire(32'(i));
    chk("t4_full_level", level, 16);
    chk("t4_no_ovf", overflow, 0);
    retire(32'd17);
    chk("t4_ovf", overflow, 1);
    chk("t4_level", level, 16);
    chk("t4_ret", retire_cnt, 17);
    do_stop(32'h0);
    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("t4_drain%0d", i), rd_data, 64'(i));
      tick();
    end
    wait_done("t4_done");
    chk("t4_pass", pass, 0);
    rd_ready = 1'b0;

    // Full FIFO with push and pop in the same cycle
    do_start();
    for (int i = 1; i <= 16; i++) retire(32'(i));
    rd_ready = 1'b1;
    retire(32'hAA);
    rd_ready = 1'b0;
    chk("t5_level", level, 16);
    chk("t5_ovf", overflow, 0);
    chk("t5_head", rd_data, 2);
    do_stop(32'h0);
    rd_ready = 1'b1;
    for (int i = 2; i <= 17; i++) begin
      chk($sformatf("t5_drain%0d", i), rd_data, (i == 17) ? 64'hAA : 64'(i));
      tick();
    end
    wait_done("t5_done");
    rd_ready = 1'b0;

    // Timeout after 1000 RUN cycles
    do_start();
    n = 0;
    while (!timeout && n < 2000) begin
      tick();
      n++;
    end
    chk("t6_to_cycles", n, 1000);
    wait_done("t6_to_done");
    chk("t6_to_flag", timeout, 1);
    chk("t6_to_pass", pass, 0);

    // Run ended by the 64th retirement
    rd_ready = 1'b1;
    do_start();
    chk("t6_to_clr", timeout, 0);
    wb_valid = 1'b1;
    n = 0;
    while (retire_cnt != 16'd64 && n < 200) begin
      wb_data = 32'(n);
      tick();
      n++;
    end
    chk("t6_ret_cycles", n, 64);
    for (int i = 0; i < 5; i++) tick();
    wb_valid = 1'b0;
    chk("t6_ret_hold", retire_cnt, 64);
    chk("t6_ret_done", done, 1);
    chk("t6_ret_to", timeout, 0);
    rd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
